param_data_memory: RTL and testbench

- Parametrised single-port synchronous data memory for the processor datapath; next generation of the 8-bit read-only-style data RAM.
- Adds: configurable width/depth, a write port, selectable read latency, read/write collision mode, and a self-initialising fill sequencer run after every reset.
- Adds an out-of-range address error flag.
- Sits between the datapath address/data buses and the register file load path.

---
 rtl/param_data_memory.sv | 84 ++++++++
 tb/tb_param_data_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
// param_data_memory: parametrised single-port data RAM with self-fill after reset,
// selectable read latency, read/write collision mode and sticky out-of-range flag.
module param_data_memory #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 61,
  parameter int READ_LATENCY = 1,
  parameter int RW_MODE      = 0,
  parameter int INIT_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  rvalid,
  output logic                  ready,
  output logic                  addr_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  typedef enum logic {INIT, READY} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         widx;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  in_range;
  logic                  rd;
  logic                  wen;
  logic                  bad;
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;
  assign idx      = addr[IW-1:0];
  assign in_range = {1'b0, addr} < DEPTH_LIM;
  assign rd       = state == READY && read_en;
  assign bad      = state == READY && (read_en || write_en) && !in_range;
  // The fill sequencer owns the single write port until the memory is ready.
  assign wen      = state == INIT || (write_en && in_range);
  assign widx     = state == INIT ? ptr : idx;
  assign wdata    = state == INIT ? (INIT_MODE == 1 ? DATA_WIDTH'(ptr) : '0) : datain;
  assign rdata    = !in_range ? '0 : (RW_MODE == 1 && write_en) ? datain : mem[idx];
  always_ff @(posedge clk)
    if (wen) mem[widx] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= INIT;
      ptr      <= '0;
      ready    <= 1'b0;
      addr_err <= 1'b0;
      v1       <= 1'b0;
      d1       <= '0;
    end else begin
      v1 <= rd;
      d1 <= rd ? rdata : '0;
      if (state == INIT) begin
        ptr <= ptr + 1'b1;
        if (ptr == IW'(DEPTH - 1)) begin
          state <= READY;
          ready <= 1'b1;
        end
      end else begin
        addr_err <= bad || (addr_err && !err_clr);
      end
    end
  if (READ_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rvalid  <= 1'b0;
        dataout <= '0;
      end else begin
        rvalid  <= v1;
        dataout <= d1;
      end
  end else begin : g_lat1
    assign rvalid  = v1;
    assign dataout = d1;
  end
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: two configurations driven by shared stimulus and checked
// every cycle against an array/queue reference model of the memory behaviour.
module tb_param_data_memory;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic [9:0]  addr = '0;
  logic [15:0] din = '0;
  logic [7:0]  dout0;
  logic        rv0, rdy0, err0;
  logic [15:0] dout1;
  logic        rv1, rdy1, err1;
  int          errors = 0;
  int          checks = 0;
  string       ph = "reset";
  int depth [2] = '{61, 1024};
  int dmask [2] = '{255, 65535};
  int amask [2] = '{255, 1023};
  int lat   [2] = '{1, 2};
  int rwm   [2] = '{0, 1};
  int initm [2] = '{1, 0};
  int mem [2][1024];
  bit rdy [2];
  int cnt [2];
  bit err [2];
  int pq0 [$];
  int pq1 [$];
  param_data_memory u0 (
    .clk(clk), .rst_n(rst_n), .read_en(re), .write_en(we), .addr(addr[7:0]),
    .datain(din[7:0]), .err_clr(clr), .dataout(dout0), .rvalid(rv0),
    .ready(rdy0), .addr_err(err0)
  );
  param_data_memory #(
    .DATA_WIDTH(16), .ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(2),
    .RW_MODE(1), .INIT_MODE(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .read_en(re), .write_en(we), .addr(addr),
    .datain(din), .err_clr(clr), .dataout(dout1), .rvalid(rv1),
    .ready(rdy1), .addr_err(err1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", ph, tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rdy[k] = 0;
      cnt[k] = 0;
      err[k] = 0;
    end
    pq0.delete();
    pq1.delete();
  endtask
  // Each accepted read yields (valid<<16 | data); the output is the one issued lat edges ago.
  task automatic model_edge(input int k);
    int a, r;
    a = int'(addr) & amask[k];
    r = 0;
    if (!rdy[k]) begin
      mem[k][cnt[k]] = initm[k] == 1 ? (cnt[k] & dmask[k]) : 0;
      cnt[k]++;
      rdy[k] = cnt[k] == depth[k];
    end else begin
      if (re) r = 32'h10000 | ((a >= depth[k]) ? 0 : (we && rwm[k] == 1) ? (int'(din) & dmask[k]) : mem[k][a]);
      if (we && a < depth[k]) mem[k][a] = int'(din) & dmask[k];
      if ((re || we) && a >= depth[k]) err[k] = 1;
      else if (clr) err[k] = 0;
    end
    if (k == 0) begin
      pq0.push_back(r);
      if (pq0.size() > lat[0]) pq0.delete(0);
    end else begin
      pq1.push_back(r);
      if (pq1.size() > lat[1]) pq1.delete(0);
    end
  endtask
  function automatic int expv(input int k);
    if (k == 0) return pq0.size() == lat[0] ? pq0[0] : 0;
    return pq1.size() == lat[1] ? pq1[0] : 0;
  endfunction
  task automatic check_all();
    int e0, e1;
    e0 = expv(0);
    e1 = expv(1);
    chk("rdy0", rdy0, rdy[0]);
    chk("rv0", rv0, (e0 >> 16) & 1);
    chk("d0", dout0, e0 & 'hFFFF);
    chk("err0", err0, err[0]);
    chk("rdy1", rdy1, rdy[1]);
    chk("rv1", rv1, (e1 >> 16) & 1);
    chk("d1", dout1, e1 & 'hFFFF);
    chk("err1", err1, err[1]);
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
  endtask
  task automatic drive(input bit r, input bit w, input int a, input int d, input bit c);
    re = r;
    we = w;
    addr = 10'(a);
    din = 16'(d);
    clr = c;
  endtask
  task automatic rand_drive();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 1) ? $urandom_range(0, 70) : $urandom_range(0, 1023),
          $urandom, $urandom_range(0, 7) == 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_d0", dout0, 0);
    chk("rst_err0", err0, 0);
    check_all();
    step();
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    int n;
    model_reset();
    #3;
    check_all();
    step();
    step();
    rst_n = 1'b1;
    ph = "init";
    n = 0;
    while (!rdy0 && n < 200) begin step(); n++; end
    chk("init_edges0", n, 61);
    while (!rdy1 && n < 2000) begin step(); n++; end
    chk("init_edges1", n, 1024);
    ph = "p1";
    drive(1, 0, 15, 0, 0); step();
    chk("d15", dout0, 15);
    chk("v15", rv0, 1);
    drive(1, 0, 0, 0, 0); step();
    chk("d0a", dout0, 0);
    chk("v0a", rv0, 1);
    drive(0, 0, 0, 0, 0); step(); step();
    ph = "p2";
    drive(0, 1, 5, 'hA5, 0); step();
    drive(1, 0, 5, 0, 0); step();
    chk("rdA5", dout0, 'hA5);
    drive(1, 1, 5, 'h3C, 0); step();
    chk("rw0_old", dout0, 'hA5);
    drive(0, 0, 0, 0, 0); step();
    chk("rw1_new", dout1, 'h3C);
    step();
    ph = "p3";
    for (int i = 1; i <= 3; i++) begin drive(0, 1, i, i, 0); step(); end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, i, 0, 0); step();
      if (i == 1) chk("lat2_first", rv1, 0);
      else chk("lat2_seq", dout1, i - 1);
    end
    drive(0, 0, 0, 0, 0); step();
    chk("lat2_last", dout1, 3);
    step();
    chk("lat2_done_v", rv1, 0);
    chk("lat2_done_d", dout1, 0);
    ph = "p4";
    drive(0, 1, 61, 'hFF, 0); step();
    chk("oob_err0", err0, 1);
    chk("oob_err1", err1, 0);
    drive(1, 0, 60, 0, 0); step();
    chk("w60", dout0, 60);
    drive(1, 0, 200, 0, 0); step();
    chk("r200_v", rv0, 1);
    chk("r200_d", dout0, 0);
    drive(0, 0, 0, 0, 1); step();
    chk("clr", err0, 0);
    drive(1, 0, 200, 0, 0); step();
    drive(1, 0, 200, 0, 1); step();
    chk("set_wins", err0, 1);
    drive(0, 0, 0, 0, 0); step();
    ph = "p5";
    do_reset();
    for (int i = 0; i < 30; i++) begin rand_drive(); step(); end
    do_reset();
    n = 0;
    while (!rdy0 && n < 200) begin rand_drive(); step(); n++; end
    chk("refill_edges0", n, 61);
    drive(1, 0, 7, 0, 0); step();
    chk("after_init7", dout0, 7);
    n++;
    drive(0, 0, 0, 0, 0);
    while (!rdy1 && n < 2000) begin step(); n++; end
    chk("refill_edges1", n, 1024);
    ph = "p6";
    for (int a = 0; a < 1024; a++) begin drive(1, 0, a, 0, 0); step(); end
    drive(0, 0, 0, 0, 0); step(); step();
    drive(0, 1, 1023, 'hBEEF, 0); step();
    chk("a1023_err", err1, 0);
    drive(1, 0, 1023, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    chk("beef", dout1, 'hBEEF);
    ph = "rand";
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rand_drive();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
